// File: rtl/gpia_pkg.sv
// Shared GPIA definitions: bus geometry, input-block register map and lane-mask helper.
package gpia_pkg;
  localparam int GPIA_DW    = 64;
  localparam int GPIA_LANES = 8;

  localparam logic [2:0] GPIA_IN_PINS   = 3'd0;
  localparam logic [2:0] GPIA_IN_EVENTS = 3'd1;
  localparam logic [2:0] GPIA_IN_IEN    = 3'd2;
  localparam logic [2:0] GPIA_IN_RISE   = 3'd3;
  localparam logic [2:0] GPIA_IN_FALL   = 3'd4;

  // Expand byte-lane strobes into a per-bit write mask.
  function automatic logic [GPIA_DW-1:0] lane_mask(input logic [GPIA_LANES-1:0] sel);
    logic [GPIA_DW-1:0] m;
    for (int n = 0; n < GPIA_LANES; n++) m[8*n +: 8] = {8{sel[n]}};
    return m;
  endfunction
endpackage

// File: rtl/gpia_input_bit.sv
// One input pin: synchroniser, previous-value flop, edge qualify and sticky event latch.
module gpia_input_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic res_i,
  input  logic pin_i,
  input  logic rise_en,
  input  logic fall_en,
  input  logic ev_clr,
  output logic s,
  output logic ev,
  output logic ev_next
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   ev_set;

  assign s       = sync[SYNC_STAGES-1];
  assign ev_set  = (s & ~prev & rise_en) | (~s & prev & fall_en);
  // A set in the same clock as a clear wins.
  assign ev_next = ev_set | (ev & ~ev_clr);

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      sync <= '0;
      prev <= 1'b0;
      ev   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin_i};
      prev <= s;
      ev   <= ev_next;
    end
  end
endmodule

// File: rtl/gpia_input_dword.sv
// 64-bit GPIA input block: synchronised pins, sticky edge events, IRQ, Wishbone slave.
module gpia_input_dword
  import gpia_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        res_i,
  input  logic [63:0] pins_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [2:0]  adr_i,
  input  logic [7:0]  sel_i,
  input  logic [63:0] dat_i,
  output logic [63:0] dat_o,
  output logic        ack_o,
  output logic        irq_o
);
  logic [GPIA_DW-1:0] pins_s, events, ev_next, ev_clr, wmask;
  logic [GPIA_DW-1:0] ien, rise, fall, ien_next, rise_next, fall_next, rd_data;
  logic               req, wr;

  // Masking with ack_o turns a held strobe into an ack every other cycle.
  assign req   = cyc_i & stb_i & ~ack_o;
  assign wr    = req & we_i;
  assign wmask = lane_mask(sel_i);

  assign ev_clr    = (wr && adr_i == GPIA_IN_EVENTS) ? (dat_i & wmask) : '0;
  assign ien_next  = (wr && adr_i == GPIA_IN_IEN)  ? ((ien  & ~wmask) | (dat_i & wmask)) : ien;
  assign rise_next = (wr && adr_i == GPIA_IN_RISE) ? ((rise & ~wmask) | (dat_i & wmask)) : rise;
  assign fall_next = (wr && adr_i == GPIA_IN_FALL) ? ((fall & ~wmask) | (dat_i & wmask)) : fall;

  always_comb begin
    rd_data = '0;
    case (adr_i)
      GPIA_IN_PINS:   rd_data = pins_s;
      GPIA_IN_EVENTS: rd_data = events;
      GPIA_IN_IEN:    rd_data = ien;
      GPIA_IN_RISE:   rd_data = rise;
      GPIA_IN_FALL:   rd_data = fall;
      default:        rd_data = '0;
    endcase
  end

  for (genvar i = 0; i < GPIA_DW; i++) begin : g_bit
    gpia_input_bit #(.SYNC_STAGES(SYNC_STAGES)) u_bit (
      .clk_i   (clk_i),
      .res_i   (res_i),
      .pin_i   (pins_i[i]),
      .rise_en (rise[i]),
      .fall_en (fall[i]),
      .ev_clr  (ev_clr[i]),
      .s       (pins_s[i]),
      .ev      (events[i]),
      .ev_next (ev_next[i])
    );
  end

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      ien   <= '0;
      rise  <= '0;
      fall  <= '0;
      dat_o <= '0;
      ack_o <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      ien   <= ien_next;
      rise  <= rise_next;
      fall  <= fall_next;
      ack_o <= req;
      if (req) dat_o <= rd_data;
      irq_o <= |(ev_next & ien_next);
    end
  end
endmodule

// File: doc/gpia_input_dword.md
Name: gpia_input_dword

Overview:
- 64-bit input-side companion of the GPIA output register; where the output register drives pins from bus writes, this block samples external pins and delivers them to the bus.
- Synchronises 64 asynchronous pins and detects rising/falling edges into sticky event latches.
- Exposes pin state, events, edge-enable and interrupt-enable registers over a single-cycle-ack Wishbone slave with byte-lane strobes.
- Drives one level interrupt toward the Kestrel-3 interrupt controller.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per pin (legal values 2..3).

Ports:
- clk_i  in  1  system clock (12.5 MHz nominal)
- res_i  in  1  reset; asynchronous, active-low
- pins_i  in  64  external pins, asynchronous to clk_i
- cyc_i  in  1  Wishbone cycle
- stb_i  in  1  Wishbone strobe
- we_i  in  1  write enable
- adr_i  in  3  register select
- sel_i  in  8  byte-lane strobes; bit n covers dat bits 8n+7..8n
- dat_i  in  64  write data
- dat_o  out  64  read data, registered
- ack_o  out  1  transfer acknowledge
- irq_o  out  1  interrupt request, level

Behaviour:
- Reset (res_i low, asynchronous): all synchroniser flops, prev, EVENTS, IEN, RISE, FALL, dat_o, ack_o and irq_o are 0. Leaving reset needs no clock.
- Synchroniser: pins_i passes through SYNC_STAGES flops; the last stage is s.
- prev <= s every clock.
- Register map (adr_i):
  - 0 PINS: RO, value s; writes ignored.
  - 1 EVENTS: read; write-1-to-clear.
  - 2 IEN: RW.
  - 3 RISE: RW.
  - 4 FALL: RW.
  - 5..7: read 0; writes ignored.
- Edge detect per bit i, every clock:
  - rise_i = s & ~prev & RISE
  - fall_i = ~s & prev & FALL
  - EVENTS[i] <= 1 if rise_i | fall_i.
- Latency: a pin change stable across edge N is visible in PINS at edge N+SYNC_STAGES, and in EVENTS one clock after that.
- Writes take effect only in byte lanes with sel_i[n]=1; other lanes keep their value.
- For EVENTS, a written 1 clears the bit and a written 0 has no effect.
- Simultaneous set and clear of the same EVENTS bit in one clock: set wins (the bit stays 1).
- Disabling RISE/FALL never clears EVENTS.
- irq_o is registered: irq_o <= |(EVENTS_next & IEN_next), i.e. it reflects the state after the current edge with one clock of latency to the pin.
- Handshake:
  - Request = cyc_i & stb_i & ~ack_o.
  - On a request, ack_o <= 1 the next edge; otherwise ack_o <= 0. Result: a one-cycle ack pulse, and a held strobe produces an ack every other cycle.
  - Write side effects commit on the same edge ack_o rises.
  - dat_o is loaded on that edge with the pre-write value of the addressed register; all 64 bits are returned regardless of sel_i.
  - dat_o holds its value when ack_o is 0.
- If cyc_i drops before ack_o, the ack still pulses; the master ignores it.
- Reset asserted mid-transfer: ack_o drops immediately, and no write commits.
- An edge pending in the synchroniser at reset is lost.

Decomposition:
- Shared package gpia_pkg holds:
  - register address constants GPIA_IN_PINS=0, GPIA_IN_EVENTS=1, GPIA_IN_IEN=2, GPIA_IN_RISE=3, GPIA_IN_FALL=4
  - data width 64 and lane count 8.
- Sub-module gpia_input_bit: one pin's synchroniser, prev flop, edge logic and EVENTS bit, with set/clear inputs.
  - Instantiated 64 times by a generate loop.
  - Bus decode, the IEN/RISE/FALL registers, the ack flop and the read mux stay in the top level.

Test Plan:
- Reset: hold res_i low with pins_i=64'hFFFF_FFFF_FFFF_FFFF → dat_o, ack_o, irq_o = 0. Release reset, then read adr 0 after 3 clocks → 64'hFFFF_FFFF_FFFF_FFFF. Read adr 1 → 0 (RISE was 0).
- Byte-lane write: write adr 3 with dat_i=64'h3C3C3C3C3C3C3C3C, sel_i=8'b00000100 → read adr 3 = 64'h00000000003C0000. Repeat for sel_i=8'b11110000 → 64'h3C3C3C3C003C0000.
- Edge capture: RISE=64'h1, FALL=64'h2, IEN=64'h3, pins_i=0. Raise bit 0 and bit 1, then drop bit 1 → EVENTS reads 64'h3 and irq_o=1, with the bit-0 event at edge SYNC_STAGES+1 after the change.
- W1C by lane: EVENTS=64'h0101, write adr 1 dat_i=64'hFFFF sel_i=8'b00000001 → EVENTS=64'h0100 and irq_o stays 1. Then write with sel_i=8'b00000010 → EVENTS=0 and irq_o=0 one clock later.
- Set beats clear: time a rising edge on bit 0 to the W1C commit edge of bit 0 → EVENTS[0] remains 1.
- Handshake and reset: hold cyc_i/stb_i high for 6 clocks → ack_o pattern 0,1,0,1,0,1. Assert res_i low while ack_o=1 → ack_o=0 immediately, and the pending write to IEN is not committed.
